// File: rtl/arb_types.sv
// Shared types for the cacheline arbiter.
//   arb_state_t    : arbiter FSM states
//   arb_owner_t    : which cache owns the pmem port
//   LINE_W_DEFAULT : cacheline width, also used by the cacheline adaptor
//   ADDR_W_DEFAULT : byte address width
package arb_types;

  localparam int LINE_W_DEFAULT = 256;
  localparam int ADDR_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_grant.sv
// Combinational winner selection for the cacheline arbiter.
// Optional build macro: CACHE_ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, D-cache over I-cache
//   defined   : when both requesters are pending, the one not served last wins
// Ports:
//   i_req_i        I-cache request pending
//   d_req_i        D-cache request pending (read or writeback)
//   last_owner_i   owner of the previous transaction (round-robin build only)
//   any_req_o      at least one request pending
//   winner_o       requester that gets the next grant
module arb_grant
  import arb_types::*;
(
  input  logic       i_req_i,
  input  logic       d_req_i,
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  input  arb_owner_t last_owner_i,
`endif
  output logic       any_req_o,
  output arb_owner_t winner_o
);

  always_comb begin
    any_req_o = i_req_i | d_req_i;
    winner_o  = d_req_i ? OWNER_D : OWNER_I;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    if (i_req_i && d_req_i) begin
      winner_o = (last_owner_i == OWNER_I) ? OWNER_D : OWNER_I;
    end
`endif
  end

endmodule

// File: rtl/cache_line_arbiter.sv
// Shares the single pmem cacheline port between the I-cache miss path and the
// D-cache miss/writeback path. One transaction at a time: the winner's request
// is latched on the grant edge, pmem strobes stay high until pmem_resp, the
// response and read line go back to the owner only, and a DONE bubble follows
// so the requester can drop its request before the next arbitration.
// Optional build macro: CACHE_ARB_ROUND_ROBIN_EN (alternating priority when
// both caches are pending; default is fixed D over I).
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   i_read, i_address                  I-cache line read request
//   i_rdata, i_resp                    I-cache returned line / done
//   d_read, d_write, d_address,
//   d_wdata                            D-cache line read / writeback request
//   d_rdata, d_resp                    D-cache returned line / done
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata           memory request (registered)
//   pmem_rdata, pmem_resp              memory response
module cache_line_arbiter
  import arb_types::*;
#(
  parameter int LINE_W = LINE_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic       any_req;
  arb_owner_t winner;
  logic       serving;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  arb_owner_t last_owner_q, last_owner_d;
`endif

  arb_grant u_grant (
    .i_req_i      (i_read),
    .d_req_i      (d_read | d_write),
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    .last_owner_i (last_owner_q),
`endif
    .any_req_o    (any_req),
    .winner_o     (winner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          if (winner == OWNER_D) begin
            state_d = SERVE_D;
            addr_d  = d_address;
            wdata_d = d_wdata;
            // An illegal read+write collapses to a writeback.
            write_d = d_write;
            read_d  = ~d_write;
          end else begin
            state_d = SERVE_I;
            addr_d  = i_address;
            wdata_d = '0;
            write_d = 1'b0;
            read_d  = 1'b1;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = DONE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        last_owner_d = owner_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWNER_I;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      last_owner_q <= OWNER_I;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Response passes straight through in the pmem_resp cycle, to the owner only.
  assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign i_resp  = serving && (owner_q == OWNER_I) && pmem_resp;
  assign d_resp  = serving && (owner_q == OWNER_D) && pmem_resp;
  assign i_rdata = (serving && (owner_q == OWNER_I)) ? pmem_rdata : '0;
  assign d_rdata = (serving && (owner_q == OWNER_D)) ? pmem_rdata : '0;

  a_d_read_write_exclusive: assert property (
    @(posedge clk) disable iff (rst) !(d_read && d_write));

  a_resp_only_when_serving: assert property (
    @(posedge clk) disable iff (rst) pmem_resp |-> serving);

endmodule

// File: tb/tb_cache_line_arbiter.sv
module tb_cache_line_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_line_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL reset_pmem_read got %0b want 0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL reset_pmem_write got %0b want 0", pmem_write); end
    checks++; if (pmem_address !== 32'h0) begin failures++; $display("FAIL reset_pmem_address got %h want 0", pmem_address); end
    checks++; if (pmem_wdata !== '0) begin failures++; $display("FAIL reset_pmem_wdata got %h want 0", pmem_wdata); end
    checks++; if ({i_resp, d_resp} !== 2'b00) begin failures++; $display("FAIL reset_resps got %b want 00", {i_resp, d_resp}); end
    checks++; if ((i_rdata !== '0) || (d_rdata !== '0)) begin failures++; $display("FAIL reset_rdata got i=%h d=%h want 0", i_rdata, d_rdata); end
  endtask

  task automatic test_lone_i_read();
    logic [LW-1:0] line;
    line = {8{32'hAAAA_AAAA}};
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0060;
    tick();
    checks++; if ({pmem_read, pmem_write} !== 2'b10) begin failures++; $display("FAIL i_grant_strobes got %b want 10", {pmem_read, pmem_write}); end
    checks++; if (pmem_address !== 32'h60) begin failures++; $display("FAIL i_grant_address got %h want 00000060", pmem_address); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if ({pmem_read, i_resp, d_resp} !== 3'b100) begin failures++; $display("FAIL i_wait_cycle%0d got read/iresp/dresp=%b want 100", c, {pmem_read, i_resp, d_resp}); end
    end
    tick();
    pmem_resp = 1'b1; pmem_rdata = line;
    #1;
    checks++; if (i_resp !== 1'b1) begin failures++; $display("FAIL i_resp got %0b want 1", i_resp); end
    checks++; if (i_rdata !== line) begin failures++; $display("FAIL i_rdata got %h want %h", i_rdata, line); end
    checks++; if ((d_resp !== 1'b0) || (d_rdata !== '0)) begin failures++; $display("FAIL i_nonowner got d_resp=%0b d_rdata=%h want 0", d_resp, d_rdata); end
    tick();
    pmem_resp = 1'b0; i_read = 1'b0;
    checks++; if ({pmem_read, i_resp} !== 2'b00) begin failures++; $display("FAIL i_done_bubble got %b want 00", {pmem_read, i_resp}); end
    tick();
    checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL i_idle_read got %0b want 0", pmem_read); end
  endtask

  task automatic test_lone_d_write();
    logic [LW-1:0] wline;
    wline = {8{32'h1234_5678}};
    do_reset();
    d_write = 1'b1; d_address = 32'h0000_1000; d_wdata = wline;
    tick();
    checks++; if ({pmem_read, pmem_write} !== 2'b01) begin failures++; $display("FAIL d_grant_strobes got %b want 01", {pmem_read, pmem_write}); end
    checks++; if (pmem_address !== 32'h1000) begin failures++; $display("FAIL d_grant_address got %h want 00001000", pmem_address); end
    checks++; if (pmem_wdata !== wline) begin failures++; $display("FAIL d_grant_wdata got %h want %h", pmem_wdata, wline); end
    tick();
    checks++; if ({pmem_write, d_resp} !== 2'b10) begin failures++; $display("FAIL d_wait got write/dresp=%b want 10", {pmem_write, d_resp}); end
    pmem_resp = 1'b1;
    #1;
    checks++; if ({d_resp, i_resp} !== 2'b10) begin failures++; $display("FAIL d_resp got d/i=%b want 10", {d_resp, i_resp}); end
    tick();
    pmem_resp = 1'b0; d_write = 1'b0;
    checks++; if ({pmem_read, pmem_write, d_resp} !== 3'b000) begin failures++; $display("FAIL d_done_bubble got %b want 000", {pmem_read, pmem_write, d_resp}); end
    tick();
    checks++; if ({pmem_read, pmem_write} !== 2'b00) begin failures++; $display("FAIL d_idle_strobes got %b want 00", {pmem_read, pmem_write}); end
  endtask

  task automatic test_simultaneous();
    logic [LW-1:0] dline, iline;
    dline = {8{32'h5555_5555}};
    iline = {8{32'hC3C3_C3C3}};
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_0080;
    d_read = 1'b1; d_address = 32'h0000_2000;
    tick();
    checks++; if ({pmem_read, pmem_address} !== {1'b1, 32'h2000}) begin failures++; $display("FAIL sim_first_grant got read=%0b addr=%h want 1/00002000", pmem_read, pmem_address); end
    tick();
    pmem_resp = 1'b1; pmem_rdata = dline;
    #1;
    checks++; if ({d_resp, i_resp} !== 2'b10) begin failures++; $display("FAIL sim_d_resp got d/i=%b want 10", {d_resp, i_resp}); end
    checks++; if (d_rdata !== dline) begin failures++; $display("FAIL sim_d_rdata got %h want %h", d_rdata, dline); end
    tick();
    pmem_resp = 1'b0; d_read = 1'b0;
    checks++; if ({pmem_read, i_resp} !== 2'b00) begin failures++; $display("FAIL sim_done got read/iresp=%b want 00", {pmem_read, i_resp}); end
    tick();
    checks++; if ({pmem_read, i_resp} !== 2'b00) begin failures++; $display("FAIL sim_idle got read/iresp=%b want 00", {pmem_read, i_resp}); end
    tick();
    checks++; if ({pmem_read, pmem_address} !== {1'b1, 32'h80}) begin failures++; $display("FAIL sim_second_grant got read=%0b addr=%h want 1/00000080", pmem_read, pmem_address); end
    pmem_resp = 1'b1; pmem_rdata = iline;
    #1;
    checks++; if ({i_resp, d_resp, i_rdata} !== {2'b10, iline}) begin failures++; $display("FAIL sim_i_resp got i/d=%b rdata=%h want 10/%h", {i_resp, d_resp}, i_rdata, iline); end
    tick();
    pmem_resp = 1'b0; i_read = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_addr [3];
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    exp_addr[0] = 32'h0000_3000; exp_addr[1] = 32'h0000_00A0; exp_addr[2] = 32'h0000_3000;
`else
    exp_addr[0] = 32'h0000_3000; exp_addr[1] = 32'h0000_3000; exp_addr[2] = 32'h0000_3000;
`endif
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_00A0;
    d_read = 1'b1; d_address = 32'h0000_3000;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++; if ({pmem_read, pmem_address} !== {1'b1, exp_addr[t]}) begin failures++; $display("FAIL b2b_grant%0d got read=%0b addr=%h want 1/%h", t, pmem_read, pmem_address, exp_addr[t]); end
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      tick();
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_transaction();
    do_reset();
    d_read = 1'b1; d_address = 32'h0000_4000;
    tick();
    checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL rstmid_grant got %0b want 1", pmem_read); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if ({pmem_read, pmem_write, pmem_address} !== {2'b00, 32'h0}) begin failures++; $display("FAIL rstmid_strobes got r/w=%b addr=%h want 00/0", {pmem_read, pmem_write}, pmem_address); end
    d_read = 1'b0; pmem_resp = 1'b1;
    #1;
    checks++; if ({d_resp, i_resp} !== 2'b00) begin failures++; $display("FAIL rstmid_resp got d/i=%b want 00", {d_resp, i_resp}); end
    tick();
    rst = 1'b0; pmem_resp = 1'b0;
    tick();
    checks++; if ({pmem_read, d_resp} !== 2'b00) begin failures++; $display("FAIL rstmid_idle got read/dresp=%b want 00", {pmem_read, d_resp}); end
  endtask

  task automatic test_held_through_done();
    int pulses;
    pulses = 0;
    do_reset();
    d_read = 1'b1; d_address = 32'h0000_5000;
    tick();
    pmem_resp = 1'b1;
    #1;
    if (d_resp === 1'b1) pulses++;
    tick();
    pmem_resp = 1'b0;
    checks++; if ({pmem_read, d_resp} !== 2'b00) begin failures++; $display("FAIL held_done got read/dresp=%b want 00", {pmem_read, d_resp}); end
    tick();
    d_read = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (d_resp === 1'b1) pulses++;
      checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL held_no_regrant%0d got %0b want 0", c, pmem_read); end
      tick();
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL held_resp_pulses got %0d want 1", pulses); end
  endtask

  initial begin
    test_reset();
    test_lone_i_read();
    test_lone_d_write();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_transaction();
    test_held_through_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
